// File: rtl/icache_if.sv
// Byte-read handshake between the instruction cache and the memory controller.
interface icache_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_byte;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_byte);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_byte);
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line read-only instruction cache.
// Same-cycle hits; a miss fills the word as four little-endian byte reads.
module icache #(
  parameter int unsigned INDEX_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_c,
  output logic        inst_available,
  output logic [31:0] inst_c,
  icache_if.master    mem
);

  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
  localparam int unsigned ENTRIES  = 1 << INDEX_BITS;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [31:0]         data_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q  [ENTRIES];
  logic [ENTRIES-1:0]  valid_q;

  logic [0:0]  state_q;
  logic [1:0]  cnt_q;
  logic [29:0] miss_base_q;
  logic [23:0] buffer_q;

  logic [INDEX_BITS-1:0] pc_idx;
  logic [TAG_BITS-1:0]   pc_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  install;
  logic                  unused_pc_lsb;

  assign pc_idx        = pc_c[INDEX_BITS+1:2];
  assign pc_tag        = pc_c[31:INDEX_BITS+2];
  assign fill_idx      = miss_base_q[INDEX_BITS-1:0];
  assign fill_tag      = miss_base_q[29:INDEX_BITS];
  assign unused_pc_lsb = ^pc_c[1:0];

  assign hit            = rst && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign inst_available = hit;
  assign inst_c         = hit ? data_q[pc_idx] : '0;

  assign install = rst && (state_q == FILL) && mem.mem_ack && (cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      miss_base_q  <= '0;
      buffer_q     <= '0;
      valid_q      <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hit) begin
            miss_base_q  <= pc_c[31:2];
            cnt_q        <= '0;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= {pc_c[31:2], 2'b00};
            state_q      <= FILL;
          end
        end
        default: begin
          if (mem.mem_ack) begin
            // Byte address is base + cnt; base is word aligned so cnt fills bits [1:0].
            if (cnt_q == 2'd3) begin
              valid_q[fill_idx] <= 1'b1;
              mem.mem_req       <= 1'b0;
              cnt_q             <= '0;
              state_q           <= IDLE;
            end else begin
              case (cnt_q)
                2'd0:    buffer_q[7:0]   <= mem.mem_byte;
                2'd1:    buffer_q[15:8]  <= mem.mem_byte;
                default: buffer_q[23:16] <= mem.mem_byte;
              endcase
              cnt_q        <= cnt_q + 2'd1;
              mem.mem_addr <= {miss_base_q, cnt_q + 2'd1};
            end
          end
        end
      endcase
    end
  end

  // Data and tag arrays carry no reset; valid_q alone gates their use.
  always_ff @(posedge clk) begin
    if (install) begin
      data_q[fill_idx] <= {mem.mem_byte, buffer_q};
      tag_q[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed-vector bench for icache with hand-computed expected words.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_c;
  logic        inst_available;
  logic [31:0] inst_c;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  icache_if mem_bus ();

  icache #(.INDEX_BITS(7)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_c           (pc_c),
    .inst_available (inst_available),
    .inst_c         (inst_c),
    .mem            (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Answers bytes first..last of a fill, withholding ack for 'waits' cycles before each.
  task automatic serve(input logic [31:0] base, input logic [31:0] word, input int waits,
                       input int first, input int last);
    logic [31:0] w;
    w = word;
    for (int k = first; k <= last; k++) begin
      for (int n = 0; n < waits; n++) begin
        mem_bus.mem_ack = 1'b0;
        check("wait_req", {31'b0, mem_bus.mem_req}, 32'd1);
        check("wait_addr", mem_bus.mem_addr, base + 32'(k));
        step();
      end
      mem_bus.mem_ack  = 1'b1;
      mem_bus.mem_byte = w[8*k +: 8];
      check("fill_req", {31'b0, mem_bus.mem_req}, 32'd1);
      check("fill_addr", mem_bus.mem_addr, base + 32'(k));
      step();
    end
    mem_bus.mem_ack = 1'b0;
  endtask

  task automatic miss_fill(input logic [31:0] pc, input logic [31:0] word, input int waits);
    pc_c = pc;
    #1;
    check("miss_avail", {31'b0, inst_available}, 32'd0);
    check("miss_inst", inst_c, 32'd0);
    check("miss_req", {31'b0, mem_bus.mem_req}, 32'd0);
    step();
    serve(pc, word, waits, 0, 3);
    check("hit_avail", {31'b0, inst_available}, 32'd1);
    check("hit_inst", inst_c, word);
    check("hit_req", {31'b0, mem_bus.mem_req}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst              = 1'b0;
    pc_c             = 32'h0;
    mem_bus.mem_ack  = 1'b0;
    mem_bus.mem_byte = 8'h00;
    repeat (3) step();
    check("rst_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("rst_addr", mem_bus.mem_addr, 32'd0);
    check("rst_avail", {31'b0, inst_available}, 32'd0);
    check("rst_inst", inst_c, 32'd0);

    // First miss at 0x0, zero-wait memory: hit 5 cycles after the miss.
    rst = 1'b1;
    miss_fill(32'h0000_0000, 32'h0000_0013, 0);

    // Immediate re-request hits with no memory traffic.
    step();
    check("reuse_avail", {31'b0, inst_available}, 32'd1);
    check("reuse_inst", inst_c, 32'h0000_0013);
    check("reuse_req", {31'b0, mem_bus.mem_req}, 32'd0);

    // Three wait cycles before every byte; address must hold.
    miss_fill(32'h0000_0004, 32'h5634_12B7, 3);

    // Alias eviction: 0x8 and 0x208 share index 2.
    miss_fill(32'h0000_0008, 32'h00A0_0093, 0);
    miss_fill(32'h0000_0208, 32'h0010_8113, 0);
    pc_c = 32'h0000_0008;
    #1;
    check("evict_avail", {31'b0, inst_available}, 32'd0);
    check("evict_inst", inst_c, 32'd0);
    miss_fill(32'h0000_0008, 32'h00A0_0093, 0);
    pc_c = 32'h0000_0208;
    #1;
    check("evicted_alias", {31'b0, inst_available}, 32'd0);
    miss_fill(32'h0000_0208, 32'h0010_8113, 0);

    // PC moves from 0x10 to 0x20 mid-fill.
    pc_c = 32'h0000_0010;
    #1;
    check("mid_miss", {31'b0, inst_available}, 32'd0);
    step();
    serve(32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0);
    pc_c = 32'h0000_0020;
    #1;
    check("mid_avail", {31'b0, inst_available}, 32'd0);
    serve(32'h0000_0010, 32'hDEAD_BEEF, 1, 1, 3);
    check("mid_idle_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("mid_idle_avail", {31'b0, inst_available}, 32'd0);
    step();
    serve(32'h0000_0020, 32'hCAFE_F00D, 0, 0, 3);
    check("mid_hit20", {31'b0, inst_available}, 32'd1);
    check("mid_inst20", inst_c, 32'hCAFE_F00D);
    pc_c = 32'h0000_0010;
    #1;
    check("mid_hit10", {31'b0, inst_available}, 32'd1);
    check("mid_inst10", inst_c, 32'hDEAD_BEEF);

    // Reset after the second byte aborts the fill and clears every entry.
    pc_c = 32'h0000_0040;
    #1;
    check("abort_miss", {31'b0, inst_available}, 32'd0);
    step();
    serve(32'h0000_0040, 32'h1234_5678, 0, 0, 1);
    rst = 1'b0;
    #1;
    check("abort_rst_avail", {31'b0, inst_available}, 32'd0);
    step();
    check("abort_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("abort_addr", mem_bus.mem_addr, 32'd0);
    check("abort_avail", {31'b0, inst_available}, 32'd0);
    rst  = 1'b1;
    pc_c = 32'h0000_0000;
    #1;
    check("cleared_0", {31'b0, inst_available}, 32'd0);
    pc_c = 32'h0000_0010;
    #1;
    check("cleared_10", {31'b0, inst_available}, 32'd0);
    miss_fill(32'h0000_0040, 32'h1234_5678, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-line instruction cache between the IF stage and the memory controller. It returns a hit in the same cycle the IF stage presents a PC. On a miss it fetches the 32-bit instruction as four byte reads over the memory-controller handshake, installs the word, and then hits. It is read-only: no stores, no coherence, no prefetch.

## Interface
- INDEX_BITS, 7, log2 of the entry count (128 entries); tag width = 30 − INDEX_BITS
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- pc_c  in  32  fetch address from IF; bits [1:0] ignored
- inst_available  out  1  pc_c hits this cycle; inst_c is valid
- inst_c  out  32  instruction word for pc_c, 0 when inst_available = 0
- mem_req  out  1  byte read request to the memory controller
- mem_addr  out  32  byte address of the current request
- mem_ack  in  1  mem_byte is valid for mem_addr this cycle
- mem_byte  in  8  returned byte

## Operation
- Address split:
  - index = pc_c[INDEX_BITS+1:2]
  - tag = pc_c[31:INDEX_BITS+2]
- Arrays:
  - data[2^INDEX_BITS] × 32
  - tag[2^INDEX_BITS] × (30 − INDEX_BITS)
  - valid[2^INDEX_BITS] × 1
- Hit (combinational): inst_available = rst && valid[index] && tag[index] == tag(pc_c).
  - inst_c = data[index] when inst_available, else 0.
  - A hit is reported in every state, including during a fill.
- State machine: IDLE, FILL.
  - IDLE: if pc_c misses, latch miss_base = {pc_c[31:2], 2'b00}, set cnt = 0, go to FILL. Otherwise stay in IDLE.
  - FILL: mem_req = 1 and mem_addr = miss_base + cnt.
    - On each cycle with mem_ack = 1: buffer[8·cnt +: 8] = mem_byte (little-endian) and cnt increments.
    - On the ack with cnt = 3: write data/tag/valid at the miss_base index using the completed word, assert valid, and return to IDLE.
    - Cycles with mem_ack = 0 change nothing.
- mem_addr and mem_req are registered state outputs. In IDLE, mem_req = 0 and mem_addr holds its last value.
- PC change mid-fill: the fill always completes and installs miss_base's word. The new pc_c is looked up as usual. If it still misses, a new fill starts from IDLE on the cycle after the install.
- A fill overwrites any existing entry at the same index (direct-mapped eviction). Nothing is written back.
- cnt is 2 bits and never wraps past 3 inside a fill.

## Timing
- Hit latency: 0 cycles (same-cycle combinational).
- Miss, with zero-wait memory (mem_ack high in every FILL cycle):
  - cycle 0: miss detected in IDLE
  - cycles 1–4: FILL, with mem_addr = base+0 … base+3
  - cycle 5: inst_available = 1
  - Total: 5 cycles from the miss to the hit.
- Each memory wait cycle adds exactly one cycle.
- mem_addr must be stable while mem_req = 1 and mem_ack = 0.
- Reset (rst = 0 at an edge):
  - state = IDLE, cnt = 0, mem_req = 0, mem_addr = 0
  - all valid bits = 0 (data and tag contents are don't-care)
- While rst = 0: inst_available = 0 and inst_c = 0.
- Reset asserted mid-FILL aborts the fill. No entry is written, and the next edge after release starts in IDLE.
- The array write and the state return to IDLE happen on the same edge. The next cycle's lookup sees the new entry.

## Test plan
- Reset, then pc_c = 0x0000_0000: inst_available = 0.
  - mem_req rises on the next edge with mem_addr = 0x0.
  - With ack every cycle and bytes 0x13, 0x00, 0x00, 0x00, inst_c = 0x0000_0013 appears 5 cycles after the miss.
- Immediate re-request of 0x0: inst_available = 1 in the same cycle, and mem_req stays 0.
- Miss at 0x0000_0004 with mem_ack withheld for 3 cycles before each byte:
  - mem_addr holds each address until its ack.
  - The word bytes 0xB7, 0x12, 0x34, 0x56 assemble to 0x5634_12B7.
- Alias eviction (INDEX_BITS = 7):
  - Fill 0x0000_0008, then 0x0000_0208 (same index).
  - 0x0000_0208 then hits, and 0x0000_0008 misses again.
- pc_c changes from 0x10 to 0x20 during the FILL for 0x10:
  - The fill for 0x10 completes.
  - The next cycle starts a fill at mem_addr = 0x20.
  - Afterwards, 0x10 and 0x20 both hit.
- rst = 0 after the second byte of a fill, then released:
  - mem_req = 0 and inst_available = 0.
  - The same pc_c misses and restarts at byte offset 0.
